// File: rtl/lift_scheduler_pkg.sv
// Shared types and constants for the SCAN lift scheduler: FSM states, direction codes,
// one-hot floor names and a small elaboration helper.
package lift_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE_UP,
        ST_MOVE_DOWN,
        ST_SETTLE,
        ST_DOOR_OPEN
    } state_t;

    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_t;

    localparam logic [2:0] FLOOR_GROUND = 3'b001;
    localparam logic [2:0] FLOOR_MID    = 3'b010;
    localparam logic [2:0] FLOOR_TOP    = 3'b100;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lift_scheduler_req_queue.sv
// Outstanding-request register for the lift: latches button presses, drops served floors,
// and splits the pending set into the floors above and below the car.
module lift_scheduler_req_queue #(
    parameter int NUM_FLOORS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req_in,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    input  logic [NUM_FLOORS-1:0] served,
    input  logic [NUM_FLOORS-1:0] door_hold,
    output logic [NUM_FLOORS-1:0] pending,
    output logic [NUM_FLOORS-1:0] above,
    output logic [NUM_FLOORS-1:0] below
);

    // A press at the floor whose door is already open only extends the dwell.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= (pending | (req_in & ~door_hold)) & ~served;
    end

    always_comb begin
        above = '0;
        below = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            for (int j = 0; j < NUM_FLOORS; j++) begin
                if (cur_floor[j] && i > j) above[i] = pending[i];
                if (cur_floor[j] && i < j) below[i] = pending[i];
            end
        end
    end

endmodule

// File: rtl/lift_scheduler.sv
// SCAN request scheduler for the one-hot floor lift: chooses targets, paces travel with
// step pulses to the floor counter and times the door dwell.
module lift_scheduler
    import lift_scheduler_pkg::*;
#(
    parameter int NUM_FLOORS    = 3,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] req_in,
    input  logic [NUM_FLOORS-1:0] cur_floor,
    output logic                  step_up,
    output logic                  step_down,
    output logic [1:0]            direction,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  floor_err
);

    localparam int TMAX = max_int(TRAVEL_CYCLES, DOOR_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] TRAVEL_END = TW'(TRAVEL_CYCLES);
    localparam logic [TW-1:0] DOOR_END   = TW'(DOOR_CYCLES);
    localparam logic [TW-1:0] TIMER_SAT  = TW'(TMAX);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    state_t                state, next_state, decision;
    dir_t                  last_dir;
    logic [TW-1:0]         timer;
    logic [NUM_FLOORS-1:0] above, below, served, door_hold;
    logic                  fault, reload, enter_door;

    assign fault      = floor_err || !$onehot(cur_floor);
    assign enter_door = (next_state == ST_DOOR_OPEN) && (state != ST_DOOR_OPEN);
    assign served     = enter_door ? cur_floor : '0;
    assign door_hold  = door_open ? cur_floor : '0;

    lift_scheduler_req_queue #(.NUM_FLOORS(NUM_FLOORS)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .cur_floor (cur_floor),
        .served    (served),
        .door_hold (door_hold),
        .pending   (pending),
        .above     (above),
        .below     (below)
    );

    // SCAN: keep the previous travel direction while it still has work.
    always_comb begin
        if (|(pending & cur_floor))                 decision = ST_DOOR_OPEN;
        else if (last_dir == DIR_UP && |above)      decision = ST_MOVE_UP;
        else if (last_dir == DIR_DOWN && |below)    decision = ST_MOVE_DOWN;
        else if (|above)                            decision = ST_MOVE_UP;
        else if (|below)                            decision = ST_MOVE_DOWN;
        else                                        decision = ST_IDLE;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        step_up    = 1'b0;
        step_down  = 1'b0;
        direction  = DIR_IDLE;
        door_open  = 1'b0;
        reload     = 1'b0;
        case (state)
            ST_IDLE: next_state = decision;
            ST_MOVE_UP: begin
                direction = DIR_UP;
                if (timer >= TRAVEL_END) begin
                    step_up    = !cur_floor[NUM_FLOORS-1];
                    next_state = ST_SETTLE;
                end
            end
            ST_MOVE_DOWN: begin
                direction = DIR_DOWN;
                if (timer >= TRAVEL_END) begin
                    step_down  = !cur_floor[0];
                    next_state = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                direction  = last_dir;
                next_state = decision;
            end
            ST_DOOR_OPEN: begin
                door_open = 1'b1;
                if (|(req_in & cur_floor)) reload = 1'b1;
                else if (timer >= DOOR_END) next_state = decision;
            end
            default: next_state = ST_IDLE;
        endcase
        // A bad floor reading or a reset in progress must never move the car or open the door.
        if (fault || rst) begin
            next_state = ST_IDLE;
            step_up    = 1'b0;
            step_down  = 1'b0;
            direction  = DIR_IDLE;
            door_open  = 1'b0;
            reload     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_dir  <= DIR_UP;
            timer     <= '0;
            floor_err <= 1'b0;
        end else begin
            state     <= next_state;
            floor_err <= !$onehot(cur_floor);
            if (state == ST_MOVE_UP)        last_dir <= DIR_UP;
            else if (state == ST_MOVE_DOWN) last_dir <= DIR_DOWN;
            if (reload || next_state != state)
                timer <= (next_state inside {ST_MOVE_UP, ST_MOVE_DOWN, ST_DOOR_OPEN}) ? TIMER_ONE : '0;
            else if (timer < TIMER_SAT)
                timer <= timer + TIMER_ONE;
        end
    end

endmodule

// File: tb/tb_lift_scheduler.sv
// Directed bench for lift_scheduler with a behavioural floor counter closing the step loop.
module tb_lift_scheduler;
    import lift_scheduler_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req_in, cur_floor, pending;
    logic         step_up, step_down, door_open, floor_err;
    logic [1:0]   direction;

    logic [N-1:0] cnt, load_val, ovr_val;
    logic         load_en, ovr_en;

    int checks = 0, errors = 0;
    int up_cnt = 0, down_cnt = 0, both_cnt = 0;
    int up_base, down_base;

    always #5 clk = ~clk;

    lift_scheduler #(.NUM_FLOORS(N), .TRAVEL_CYCLES(8), .DOOR_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .cur_floor (cur_floor),
        .step_up   (step_up),
        .step_down (step_down),
        .direction (direction),
        .door_open (door_open),
        .pending   (pending),
        .floor_err (floor_err)
    );

    assign cur_floor = ovr_en ? ovr_val : cnt;

    always @(posedge clk) begin
        if (load_en)        cnt <= load_val;
        else if (step_up)   cnt <= cnt << 1;
        else if (step_down) cnt <= cnt >> 1;
    end

    always @(posedge clk) begin
        if (step_up)              up_cnt++;
        if (step_down)            down_cnt++;
        if (step_up && step_down) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic [N-1:0] r);
        req_in = r;
        @(negedge clk);
        req_in = '0;
    endtask

    task automatic load(input logic [N-1:0] v);
        load_en  = 1'b1;
        load_val = v;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    // Negedges until door_open is seen; a timeout yields a count that cannot match.
    task automatic wait_door(input string tag, input int exp_n);
        int n = 0;
        while (n <= exp_n + 20) begin
            @(negedge clk);
            n++;
            if (door_open) break;
        end
        check(tag, n, exp_n);
    endtask

    // Consecutive negedges with door_open high, starting with the current one.
    task automatic door_len(input string tag, input int exp_n);
        int n = 0;
        while (door_open && n < 50) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp_n);
    endtask

    initial begin
        rst = 1'b1; req_in = '0; ovr_en = 1'b0; ovr_val = '0;
        load_en = 1'b1; load_val = FLOOR_GROUND;
        cyc(2);
        rst = 1'b0; load_en = 1'b0;
        check("rst_dir", direction, DIR_IDLE);
        check("rst_door", door_open, 0);
        check("rst_pending", pending, 0);
        check("rst_steps", {step_up, step_down}, 0);
        check("rst_floor_err", floor_err, 0);

        // Two-floor trip 001 -> 100.
        up_base = up_cnt;
        press(FLOOR_TOP);
        check("a_latch", pending, FLOOR_TOP);
        cyc(1);
        check("a_dir_up", direction, DIR_UP);
        wait_door("a_door_lat", 18);
        check("a_floor", cur_floor, FLOOR_TOP);
        check("a_pending", pending, 0);
        check("a_steps", up_cnt - up_base, 2);
        door_len("a_door_len", 4);
        check("a_idle_dir", direction, DIR_IDLE);

        // Reach 010 travelling up, then 101 together: top first, then ground.
        load(FLOOR_GROUND);
        press(FLOOR_MID);
        wait_door("b_door_mid", 10);
        door_len("b_door_mid_len", 4);
        press(FLOOR_TOP | FLOOR_GROUND);
        wait_door("b_door_top", 10);
        check("b_floor_top", cur_floor, FLOOR_TOP);
        check("b_pend_after_top", pending, FLOOR_GROUND);
        door_len("b_door_top_len", 4);
        check("b_dir_down", direction, DIR_DOWN);
        wait_door("b_door_gnd", 18);
        check("b_floor_gnd", cur_floor, FLOOR_GROUND);
        check("b_pending", pending, 0);
        door_len("b_door_gnd_len", 4);

        // Door at 010 extended by a same-floor press on door cycle 3.
        press(FLOOR_MID);
        wait_door("c_door", 10);
        cyc(2);
        press(FLOOR_MID);
        check("c_pending", pending, 0);
        check("c_door_held", door_open, 1);
        door_len("c_door_ext", 4);
        check("c_floor", cur_floor, FLOOR_MID);

        // At 100 with 100 and 001 pressed together: open here, then two floors down.
        load(FLOOR_TOP);
        down_base = down_cnt;
        press(FLOOR_TOP | FLOOR_GROUND);
        check("d_latch", pending, FLOOR_TOP | FLOOR_GROUND);
        wait_door("d_door_here", 1);
        check("d_pend_served", pending, FLOOR_GROUND);
        door_len("d_door_len", 4);
        check("d_dir_down", direction, DIR_DOWN);
        wait_door("d_door_gnd", 18);
        check("d_floor", cur_floor, FLOOR_GROUND);
        check("d_steps", down_cnt - down_base, 2);
        door_len("d_door_gnd_len", 4);

        // Multi-hot floor reading in the middle of MOVE_DOWN.
        load(FLOOR_TOP);
        press(FLOOR_GROUND);
        cyc(3);
        ovr_val = 3'b011; ovr_en = 1'b1;
        up_base = up_cnt; down_base = down_cnt;
        cyc(1);
        check("e_err_set", floor_err, 1);
        check("e_err_dir", direction, DIR_IDLE);
        check("e_err_door", door_open, 0);
        cyc(3);
        check("e_err_steps", (up_cnt - up_base) + (down_cnt - down_base), 0);
        check("e_err_pending", pending, FLOOR_GROUND);
        check("e_err_hold", floor_err, 1);
        ovr_val = FLOOR_MID; load_val = FLOOR_MID; load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0; ovr_en = 1'b0;
        check("e_err_clear", floor_err, 0);
        cyc(1);
        check("e_resume_dir", direction, DIR_DOWN);
        wait_door("e_door", 9);
        check("e_floor", cur_floor, FLOOR_GROUND);
        door_len("e_door_len", 4);

        // Reset in the middle of MOVE_UP.
        press(FLOOR_TOP);
        cyc(4);
        rst = 1'b1;
        up_base = up_cnt; down_base = down_cnt;
        cyc(2);
        rst = 1'b0;
        check("r_dir", direction, DIR_IDLE);
        check("r_door", door_open, 0);
        check("r_pending", pending, 0);
        check("r_floor_err", floor_err, 0);
        check("r_steps_now", {step_up, step_down}, 0);
        cyc(4);
        check("r_no_steps", (up_cnt - up_base) + (down_cnt - down_base), 0);
        check("r_idle_dir", direction, DIR_IDLE);
        check("r_floor", cur_floor, FLOOR_GROUND);

        check("both_steps", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
